// File: rtl/sram_pkg.sv
// Shared widths, owner-state encoding and port ids for the SRAM arbiter slice.
package sram_pkg;

    localparam int A_WIDTH_DEF = 15;
    localparam int D_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Read-return tag carried alongside the SRAM pipeline.
    typedef struct packed {
        logic vld;
        logic port;
    } tag_t;

endpackage

// File: rtl/sram_rr_grant.sv
// Combinational two-port round-robin grant with bounded lock retention.
// Zero latency; a port without a grant simply waits (its Req stays high).
module sram_rr_grant
    import sram_pkg::*;
#(
    parameter int MAX_LOCK = 4
) (
    input  logic       req_a,
    input  logic       req_b,
    input  logic       lock_last,
    input  owner_t     owner,
    input  logic       last,
    input  logic [3:0] lock_cnt,
    output logic       gnt_a,
    output logic       gnt_b
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    logic hold;

    // The owner keeps the bus under contention only while its lock budget lasts.
    assign hold = (owner != OWN_NONE) && lock_last && (lock_cnt < MAX_CNT);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && !req_b) begin
            gnt_a = 1'b1;
        end else if (req_b && !req_a) begin
            gnt_b = 1'b1;
        end else if (req_a && req_b) begin
            if (hold) begin
                gnt_a = (owner == OWN_A);
                gnt_b = (owner == OWN_B);
            end else begin
                gnt_a = (last == PORT_B);
                gnt_b = (last == PORT_A);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises port A/B requests onto one single-port SRAM and routes read data back.
// Ack same cycle, command one cycle later, read data two cycles after Ack.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req_A,
    input  logic               Wr_A,
    input  logic               Lock_A,
    input  logic [A_WIDTH-1:0] Addr_A,
    input  logic [D_WIDTH-1:0] WData_A,
    input  logic               Req_B,
    input  logic               Wr_B,
    input  logic               Lock_B,
    input  logic [A_WIDTH-1:0] Addr_B,
    input  logic [D_WIDTH-1:0] WData_B,
    output logic               Ack_A,
    output logic               Ack_B,
    output logic               RValid_A,
    output logic               RValid_B,
    output logic [D_WIDTH-1:0] RData_A,
    output logic [D_WIDTH-1:0] RData_B,
    output logic               Mem_En,
    output logic               Mem_RW,
    output logic [A_WIDTH-1:0] Mem_Addr,
    output logic [D_WIDTH-1:0] Mem_Din,
    input  logic [D_WIDTH-1:0] Mem_Dout
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    owner_t             owner, owner_nxt;
    logic               last, last_nxt;
    logic               lock_q, lock_q_nxt;
    logic [3:0]         lock_cnt, lock_cnt_nxt;
    logic               req_a, req_b;
    logic               gnt_a, gnt_b, gnt;
    logic               gnt_port, gnt_wr, gnt_lock;
    logic [A_WIDTH-1:0] gnt_addr;
    logic [D_WIDTH-1:0] gnt_wdata;
    tag_t               tag_s1, tag_s2;

    // Nothing is granted while reset is asserted.
    assign req_a = Req_A & ~Rst;
    assign req_b = Req_B & ~Rst;

    sram_rr_grant #(
        .MAX_LOCK (MAX_LOCK)
    ) u_grant (
        .req_a     (req_a),
        .req_b     (req_b),
        .lock_last (lock_q),
        .owner     (owner),
        .last      (last),
        .lock_cnt  (lock_cnt),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b)
    );

    assign gnt       = gnt_a | gnt_b;
    assign gnt_port  = gnt_b ? PORT_B : PORT_A;
    assign gnt_wr    = gnt_b ? Wr_B    : Wr_A;
    assign gnt_lock  = gnt_b ? Lock_B  : Lock_A;
    assign gnt_addr  = gnt_b ? Addr_B  : Addr_A;
    assign gnt_wdata = gnt_b ? WData_B : WData_A;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            owner    <= OWN_NONE;
            last     <= PORT_B;
            lock_q   <= 1'b0;
            lock_cnt <= 4'd0;
        end else begin
            owner    <= owner_nxt;
            last     <= last_nxt;
            lock_q   <= lock_q_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        owner_nxt    = OWN_NONE;
        last_nxt     = last;
        lock_q_nxt   = lock_q;
        lock_cnt_nxt = 4'd0;
        if (gnt) begin
            owner_nxt  = gnt_b ? OWN_B : OWN_A;
            last_nxt   = gnt_port;
            lock_q_nxt = gnt_lock;
            // Saturate so a lone locked requester cannot wrap the counter.
            if (gnt_port == last && gnt_lock)
                lock_cnt_nxt = (lock_cnt >= MAX_CNT) ? MAX_CNT : lock_cnt + 4'd1;
            else
                lock_cnt_nxt = 4'd1;
        end
    end

    always_comb begin
        Ack_A    = gnt_a;
        Ack_B    = gnt_b;
        RValid_A = tag_s2.vld && (tag_s2.port == PORT_A);
        RValid_B = tag_s2.vld && (tag_s2.port == PORT_B);
        RData_A  = RValid_A ? Mem_Dout : '0;
        RData_B  = RValid_B ? Mem_Dout : '0;
    end

    // Issue stage and read-return tag pipeline.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Mem_En   <= 1'b0;
            Mem_RW   <= 1'b0;
            Mem_Addr <= '0;
            Mem_Din  <= '0;
            tag_s1   <= '0;
            tag_s2   <= '0;
        end else begin
            tag_s2 <= tag_s1;
            if (gnt) begin
                Mem_En      <= 1'b1;
                Mem_RW      <= gnt_wr;
                Mem_Addr    <= gnt_addr;
                Mem_Din     <= gnt_wr ? gnt_wdata : '0;
                tag_s1.vld  <= ~gnt_wr;
                tag_s1.port <= gnt_port;
            end else begin
                Mem_En <= 1'b0;
                Mem_RW <= 1'b0;
                tag_s1 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural one-cycle SRAM model.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req_A = 1'b0, Wr_A = 1'b0, Lock_A = 1'b0;
    logic        Req_B = 1'b0, Wr_B = 1'b0, Lock_B = 1'b0;
    logic [14:0] Addr_A = '0, Addr_B = '0;
    logic [7:0]  WData_A = '0, WData_B = '0;
    logic        Ack_A, Ack_B, RValid_A, RValid_B;
    logic [7:0]  RData_A, RData_B;
    logic        Mem_En, Mem_RW;
    logic [14:0] Mem_Addr;
    logic [7:0]  Mem_Din;
    logic [7:0]  Mem_Dout = '0;

    logic [7:0]  mem [0:32767];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic        pend_a = 1'b0, pend_b = 1'b0;

    always #5 Clk = ~Clk;

    sram_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .Req_A(Req_A), .Wr_A(Wr_A), .Lock_A(Lock_A), .Addr_A(Addr_A), .WData_A(WData_A),
        .Req_B(Req_B), .Wr_B(Wr_B), .Lock_B(Lock_B), .Addr_B(Addr_B), .WData_B(WData_B),
        .Ack_A(Ack_A), .Ack_B(Ack_B),
        .RValid_A(RValid_A), .RValid_B(RValid_B), .RData_A(RData_A), .RData_B(RData_B),
        .Mem_En(Mem_En), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr), .Mem_Din(Mem_Din),
        .Mem_Dout(Mem_Dout)
    );

    initial for (int i = 0; i < 32768; i++) mem[i] = 8'h00;

    // SRAM model: registered read, output zero when no read is issued.
    always @(posedge Clk) begin
        if (Mem_En && Mem_RW) mem[Mem_Addr] <= Mem_Din;
        Mem_Dout <= (Mem_En && !Mem_RW) ? mem[Mem_Addr] : 8'h00;
    end

    // A request that was not acked must still be present the next cycle.
    always @(negedge Clk) begin
        if (pend_a) assert (Req_A) else begin
            n_total++; n_fail++;
            $error("FAIL req_a_dropped: Req_A observed 0 required 1");
        end
        if (pend_b) assert (Req_B) else begin
            n_total++; n_fail++;
            $error("FAIL req_b_dropped: Req_B observed 0 required 1");
        end
        pend_a <= Req_A && !Ack_A && !Rst;
        pend_b <= Req_B && !Ack_B && !Rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        @(negedge Clk);
    endtask

    task automatic drive(input logic ra, input logic wa, input logic la,
                         input logic [14:0] aa, input logic [7:0] da,
                         input logic rb, input logic wb, input logic lb,
                         input logic [14:0] ab, input logic [7:0] db);
        Req_A = ra; Wr_A = wa; Lock_A = la; Addr_A = aa; WData_A = da;
        Req_B = rb; Wr_B = wb; Lock_B = lb; Addr_B = ab; WData_B = db;
    endtask

    task automatic idle();
        drive(0, 0, 0, 15'h0, 8'h0, 0, 0, 0, 15'h0, 8'h0);
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        tick(); tick();
        mid();
        chk("rst_ack",    {Ack_A, Ack_B}, 2'b00);
        chk("rst_en_rw",  {Mem_En, Mem_RW}, 2'b00);
        chk("rst_addr",   Mem_Addr, 15'h0);
        chk("rst_din",    Mem_Din, 8'h0);
        chk("rst_rvalid", {RValid_A, RValid_B}, 2'b00);
        chk("rst_rdata",  {RData_A, RData_B}, 16'h0);

        // Write then read the same address from port A.
        tick(); Rst = 1'b0;
        drive(1, 1, 0, 15'h0010, 8'h5A, 0, 0, 0, 15'h0, 8'h0);
        mid(); chk("c1_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); drive(1, 0, 0, 15'h0010, 8'h00, 0, 0, 0, 15'h0, 8'h0);
        mid(); chk("c2_ack", {Ack_A, Ack_B}, 2'b10);
        chk("c2_en_rw", {Mem_En, Mem_RW}, 2'b11);
        chk("c2_addr",  Mem_Addr, 15'h0010);
        chk("c2_din",   Mem_Din, 8'h5A);
        tick(); idle();
        mid(); chk("c3_ack", {Ack_A, Ack_B}, 2'b00);
        chk("c3_en_rw",   {Mem_En, Mem_RW}, 2'b10);
        chk("c3_din",     Mem_Din, 8'h00);
        chk("c3_rvalid",  {RValid_A, RValid_B}, 2'b00);
        tick();
        mid(); chk("c4_rvalid", {RValid_A, RValid_B}, 2'b10);
        chk("c4_rdata_a", RData_A, 8'h5A);
        chk("c4_rdata_b", RData_B, 8'h00);
        chk("c4_en_rw",   {Mem_En, Mem_RW}, 2'b00);
        chk("c4_addr",    Mem_Addr, 15'h0010);

        // One-cycle reset, then unlocked contention alternates A,B,A,B.
        tick(); Rst = 1'b1;
        tick(); Rst = 1'b0;
        drive(1, 0, 0, 15'h0100, 8'h0, 1, 0, 0, 15'h0200, 8'h0);
        mid(); chk("c6_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); mid(); chk("c7_ack", {Ack_A, Ack_B}, 2'b01);
        chk("c7_addr", Mem_Addr, 15'h0100);
        tick(); mid(); chk("c8_ack", {Ack_A, Ack_B}, 2'b10);
        chk("c8_addr",   Mem_Addr, 15'h0200);
        chk("c8_rvalid", {RValid_A, RValid_B}, 2'b10);
        tick(); mid(); chk("c9_ack", {Ack_A, Ack_B}, 2'b01);
        chk("c9_addr",   Mem_Addr, 15'h0100);
        chk("c9_rvalid", {RValid_A, RValid_B}, 2'b01);

        // A now locks: four A grants, forced switch to B, then A again.
        tick(); Lock_A = 1'b1;
        mid(); chk("c10_ack", {Ack_A, Ack_B}, 2'b10);
        chk("c10_addr", Mem_Addr, 15'h0200);
        tick(); mid(); chk("c11_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); mid(); chk("c12_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); mid(); chk("c13_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); mid(); chk("c14_ack", {Ack_A, Ack_B}, 2'b01);
        tick(); mid(); chk("c15_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); drive(0, 0, 0, 15'h0, 8'h0, 1, 0, 0, 15'h0200, 8'h0);
        mid(); chk("c16_ack", {Ack_A, Ack_B}, 2'b01);
        tick(); idle();
        mid(); chk("c17_ack", {Ack_A, Ack_B}, 2'b00);

        // A writes the top address, B reads it back the next cycle.
        tick(); drive(1, 1, 0, 15'h7FFF, 8'hC3, 0, 0, 0, 15'h0, 8'h0);
        mid(); chk("c18_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); drive(0, 0, 0, 15'h0, 8'h0, 1, 0, 0, 15'h7FFF, 8'h0);
        mid(); chk("c19_ack", {Ack_A, Ack_B}, 2'b01);
        chk("c19_en_rw", {Mem_En, Mem_RW}, 2'b11);
        chk("c19_addr",  Mem_Addr, 15'h7FFF);
        chk("c19_din",   Mem_Din, 8'hC3);
        tick(); idle();
        mid(); chk("c20_en_rw", {Mem_En, Mem_RW}, 2'b10);
        chk("c20_addr", Mem_Addr, 15'h7FFF);
        tick(); mid();
        chk("c21_rvalid", {RValid_A, RValid_B}, 2'b01);
        chk("c21_rdata_b", RData_B, 8'hC3);
        chk("c21_rdata_a", RData_A, 8'h00);

        // Read acked, reset next cycle: the read must never return.
        tick(); drive(1, 0, 0, 15'h0010, 8'h0, 0, 0, 0, 15'h0, 8'h0);
        mid(); chk("c22_ack", {Ack_A, Ack_B}, 2'b10);
        tick(); Rst = 1'b1;
        drive(1, 0, 0, 15'h0010, 8'h0, 1, 0, 0, 15'h0200, 8'h0);
        mid(); chk("c23_ack_in_rst", {Ack_A, Ack_B}, 2'b00);
        tick(); Rst = 1'b0;
        mid();
        chk("c24_rvalid", {RValid_A, RValid_B}, 2'b00);
        chk("c24_rdata",  {RData_A, RData_B}, 16'h0);
        chk("c24_en_rw",  {Mem_En, Mem_RW}, 2'b00);
        chk("c24_addr",   Mem_Addr, 15'h0);
        chk("c24_din",    Mem_Din, 8'h0);
        chk("c24_ack",    {Ack_A, Ack_B}, 2'b10);
        tick(); drive(0, 0, 0, 15'h0, 8'h0, 1, 0, 0, 15'h0200, 8'h0);
        mid(); chk("c25_ack", {Ack_A, Ack_B}, 2'b01);
        chk("c25_addr", Mem_Addr, 15'h0010);
        tick(); idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester round-robin arbiter and sequencer for the team's single-port synchronous SRAM (15-bit address, 8-bit data, one-cycle registered read, write on RW=1). It accepts independent read/write requests from ports A and B, serialises them onto the single SRAM command bus, and returns read data to the originating port. It supports one SRAM access per cycle and a bounded lock so a requester can issue short back-to-back bursts.

## Interface
- A_WIDTH, 15, SRAM address width
- D_WIDTH, 8, SRAM data width
- MAX_LOCK, 4, max consecutive locked grants before a forced switch (1..15)
- Clk  in  1  clock, all logic on posedge
- Rst  in  1  reset, synchronous, active-high
- Req_A / Req_B  in  1  access request; held with fields stable until Ack
- Wr_A / Wr_B  in  1  1 = write, 0 = read
- Lock_A / Lock_B  in  1  request priority retention for the next grant
- Addr_A / Addr_B  in  A_WIDTH  word address
- WData_A / WData_B  in  D_WIDTH  write data
- Ack_A / Ack_B  out  1  request accepted this cycle (combinational)
- RValid_A / RValid_B  out  1  read data valid
- RData_A / RData_B  out  D_WIDTH  read data; 0 when RValid low
- Mem_En  out  1  SRAM enable (registered)
- Mem_RW  out  1  SRAM write strobe (registered)
- Mem_Addr  out  A_WIDTH  SRAM address (registered)
- Mem_Din  out  D_WIDTH  SRAM write data (registered)
- Mem_Dout  in  D_WIDTH  SRAM read data (zero when no read was issued)

## Operation
- Owner state: OWN_NONE, OWN_A, OWN_B, plus Last (last granted port) and 4-bit LockCnt.
- Grant rule each cycle, Rst low:
  - only one Req: grant it;
  - both Req and current owner holds lock (Lock of last grant = 1 and LockCnt < MAX_LOCK): grant owner;
  - both Req otherwise: grant the port != Last.
- On grant: Ack_x=1; Last<=x; issue registers load En=1, RW=Wr_x, Addr_x, WData_x (Din=0 on reads); tag register records {read, port}.
- LockCnt: same port granted again with its Lock set -> LockCnt+1; otherwise 1 on a grant, 0 on an idle cycle. Forced switch at LockCnt == MAX_LOCK only if the other port requests.
- No grant: Mem_En<=0, Mem_RW<=0, Addr/Din hold.
- Read return: tag delayed one stage; RValid_x=1 and RData_x=Mem_Dout for the tagged port only; the other port sees RValid=0, RData=0.
- Writes produce no response beyond Ack.
- Rst: Ack_A/B=0, Mem_En=0, Mem_RW=0, Mem_Addr=0, Mem_Din=0, RValid_A/B=0, RData_A/B=0, Last=B (A wins first contention), LockCnt=0, owner OWN_NONE. In-flight reads are dropped with no RValid, even if Rst is one cycle.

## Timing
- Cycle t: Req sampled, Ack asserted.
- t+1: SRAM command on Mem_*.
- t+2: RValid/RData for reads.
- Read latency from Ack: 2 cycles. Throughput: 1 access/cycle aggregate.
- A requester may present a new request in t+1. Write at t followed by a read of the same address at t+1 returns the new data, because the SRAM is in order.
- Simultaneous Req with Lock but LockCnt==MAX_LOCK: grant the other port, reset LockCnt to 1.
- Req dropped before Ack: illegal (assertion in bench), no state change required.

## Structure
- Shared package sram_pkg: A_WIDTH/D_WIDTH defaults, owner-state encoding (OWN_NONE=0, OWN_A=1, OWN_B=2), port-id constants.
- One natural sub-module: sram_rr_grant (combinational grant decision from Req, Lock, Last, LockCnt). Issue and return pipeline stays in the top.

## Test plan
- Single read: after Rst, Req_A write 0x0010<-0x5A, then Req_A read 0x0010 -> Ack_A each cycle, RValid_A two cycles after read Ack with RData_A=0x5A; RValid_B stays 0.
- Contention: Req_A and Req_B held for 4 cycles, Lock low -> grants A,B,A,B; Mem_Addr alternates.
- Lock bound: MAX_LOCK=4, Req_A+Lock_A and Req_B held continuously -> grants A,A,A,A,B,A...
- Back-to-back mixed: B reads 0x7FFF while A writes 0x7FFF<-0xC3 granted earlier -> B reads 0xC3; wrap address 0x7FFF is accepted.
- Reset mid-operation: read Acked at t, Rst high at t+1 -> no RValid at t+2, all outputs 0, and the next contention grants A first.
